pps_discipline_ctrl: RTL and testbench

- Controller that disciplines a local one-second timebase against the single-cycle PPS pulse from the PPS receiver.
- Sequences acquisition, lock, holdover and free-run. Generates the fabric PPS from an internal second counter, so PPS continues when the external reference is lost.
- Reports lock state and the per-second phase error to software/status logic.

---
 rtl/pps_discipline_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pps_discipline_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pps_discipline_ctrl.sv
// Disciplines a local one-second counter against an external PPS pulse and
// sequences FREERUN / ACQUIRE / LOCKED / HOLDOVER, reporting per-second phase error.
module pps_discipline_ctrl #(
   parameter int C_CLOCK_FREQUENCY  = 125000000,
   parameter int C_TOLERANCE        = 100,
   parameter int C_LOCK_COUNT       = 3,
   parameter int C_HOLDOVER_SECONDS = 60,
   localparam int W = $clog2(C_CLOCK_FREQUENCY)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              force_freerun,
   input  logic              pps_in,
   output logic              pps_out,
   output logic              pps_locked,
   output logic [1:0]        state,
   output logic signed [W:0] phase_err,
   output logic              phase_err_valid
);

   localparam int GW = $clog2(C_LOCK_COUNT + 1);
   localparam int HW = $clog2(C_HOLDOVER_SECONDS + 1);

   localparam logic [W-1:0]      CNT_MAX   = W'(C_CLOCK_FREQUENCY - 1);
   localparam logic [W-1:0]      CNT_HALF  = W'(C_CLOCK_FREQUENCY / 2);
   localparam logic [W:0]        F_EXT     = (W+1)'(C_CLOCK_FREQUENCY);
   localparam logic [W:0]        IVL_MIN   = (W+1)'(C_CLOCK_FREQUENCY - C_TOLERANCE);
   localparam logic [W:0]        IVL_MAX   = (W+1)'(C_CLOCK_FREQUENCY + C_TOLERANCE);
   localparam logic [W:0]        IVL_TO    = (W+1)'(C_CLOCK_FREQUENCY + C_TOLERANCE + 1);
   localparam logic [W:0]        IVL_SAT   = '1;
   localparam logic signed [W:0] TOL_P     = (W+1)'(C_TOLERANCE);
   localparam logic signed [W:0] TOL_N     = -TOL_P;
   localparam logic [GW-1:0]     LOCK_LAST = GW'(C_LOCK_COUNT - 1);
   localparam logic [HW-1:0]     HOLD_LAST = HW'(C_HOLDOVER_SECONDS - 1);

   typedef enum logic [1:0] {
      FREERUN  = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2,
      HOLDOVER = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      cnt_q, cnt_d;
   logic [W:0]        ivl_q, ivl_d;
   logic [GW-1:0]     good_q, good_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic              pps_out_q, pps_out_d;
   logic              locked_q, locked_d;
   logic signed [W:0] perr_q, perr_d;
   logic              perr_vld_q, perr_vld_d;

   logic              active;
   logic              take;
   logic              suppress;
   logic              ivl_good;
   logic              timeout;
   logic              hold_term;
   logic              abs_ok;
   logic [W:0]        cnt_ext;
   logic signed [W:0] err;

   always_comb begin
      active    = enable && !force_freerun;
      take      = active && pps_in;
      cnt_ext   = {1'b0, cnt_q};
      err       = (cnt_q < CNT_HALF) ? cnt_ext : (cnt_ext - F_EXT);
      abs_ok    = (err <= TOL_P) && (err >= TOL_N);
      ivl_good  = (ivl_q >= IVL_MIN) && (ivl_q <= IVL_MAX);
      timeout   = (ivl_q >= IVL_TO);
      hold_term = pps_out_q && (hold_q == HOLD_LAST);
      // A late pulse while locked/holding arrives after this second's pulse already fired.
      suppress  = ((state_q == LOCKED) || (state_q == HOLDOVER)) && !err[W] && (|err);
   end

   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      hold_d     = hold_q;
      cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + W'(1);
      ivl_d      = (ivl_q == IVL_SAT) ? ivl_q : ivl_q + (W+1)'(1);
      perr_d     = perr_q;
      perr_vld_d = take;

      if (take) begin
         cnt_d  = W'(1);
         ivl_d  = (W+1)'(1);
         perr_d = err;
      end

      if (!active) begin
         state_d = FREERUN;
         good_d  = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            FREERUN: begin
               if (pps_in) begin
                  state_d = ACQUIRE;
                  good_d  = GW'(1);
               end
            end
            ACQUIRE: begin
               if (pps_in) begin
                  if (ivl_good) begin
                     good_d = good_q + GW'(1);
                     if (good_q >= LOCK_LAST) state_d = LOCKED;
                  end else begin
                     good_d = GW'(1);
                  end
               end else if (timeout) begin
                  state_d = FREERUN;
                  good_d  = '0;
               end
            end
            LOCKED: begin
               if (pps_in) begin
                  if (!(ivl_good && abs_ok)) begin
                     state_d = ACQUIRE;
                     good_d  = GW'(1);
                  end
               end else if (timeout) begin
                  state_d = HOLDOVER;
                  hold_d  = '0;
               end
            end
            HOLDOVER: begin
               if (pps_in) begin
                  hold_d = '0;
                  if (abs_ok) begin
                     state_d = LOCKED;
                  end else begin
                     state_d = ACQUIRE;
                     good_d  = GW'(1);
                  end
               end else if (hold_term) begin
                  state_d = FREERUN;
                  hold_d  = '0;
               end else if (pps_out_q) begin
                  hold_d = hold_q + HW'(1);
               end
            end
            default: state_d = FREERUN;
         endcase
      end

      // Never stretch a pulse that is already on the output into two cycles.
      pps_out_d = take ? (!suppress && !pps_out_q) : (cnt_q == '0);
      locked_d  = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FREERUN;
         cnt_q      <= '0;
         ivl_q      <= '0;
         good_q     <= '0;
         hold_q     <= '0;
         pps_out_q  <= 1'b0;
         locked_q   <= 1'b0;
         perr_q     <= '0;
         perr_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ivl_q      <= ivl_d;
         good_q     <= good_d;
         hold_q     <= hold_d;
         pps_out_q  <= pps_out_d;
         locked_q   <= locked_d;
         perr_q     <= perr_d;
         perr_vld_q <= perr_vld_d;
      end
   end

   assign pps_out         = pps_out_q;
   assign pps_locked      = locked_q;
   assign state           = state_q;
   assign phase_err       = perr_q;
   assign phase_err_valid = perr_vld_q;

endmodule

// File: tb/tb_pps_discipline_ctrl.sv
// Scoreboard bench for pps_discipline_ctrl: stimulus pushes expected pps_out and
// phase_err events, a negedge monitor pops and compares them as the DUT emits them.
module tb_pps_discipline_ctrl;

   localparam int F     = 1000;
   localparam int TOL   = 10;
   localparam int LOCKN = 3;
   localparam int HOLDN = 2;
   localparam int W     = $clog2(F);

   typedef struct {
      int cycle;
      int value;
   } errEvent_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b1;
   logic              forceFreerun = 1'b0;
   logic              ppsIn = 1'b0;
   logic              ppsOut;
   logic              ppsLocked;
   logic [1:0]        state;
   logic signed [W:0] phaseErr;
   logic              phaseErrValid;

   int        cyc;
   int        checks = 0;
   int        errors = 0;
   int        ppsQ[$];
   errEvent_t errQ[$];
   int        expPps;
   errEvent_t expErr;

   pps_discipline_ctrl #(
      .C_CLOCK_FREQUENCY (F),
      .C_TOLERANCE       (TOL),
      .C_LOCK_COUNT      (LOCKN),
      .C_HOLDOVER_SECONDS(HOLDN)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .force_freerun  (forceFreerun),
      .pps_in         (ppsIn),
      .pps_out        (ppsOut),
      .pps_locked     (ppsLocked),
      .state          (state),
      .phase_err      (phaseErr),
      .phase_err_valid(phaseErrValid)
   );

   always #5 clk = ~clk;

   // Cycle index: number of rising edges since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input integer actual, input integer expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // Monitor: every emitted pulse or phase strobe must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ppsOut) begin
            expPps = (ppsQ.size() != 0) ? ppsQ.pop_front() : -1;
            checkOutput("pps_out_cycle", cyc, expPps);
         end
         if (phaseErrValid) begin
            if (errQ.size() != 0) begin
               expErr = errQ.pop_front();
            end else begin
               expErr.cycle = -1;
               expErr.value = 0;
            end
            checkOutput("phase_err_cycle", cyc, expErr.cycle);
            checkOutput("phase_err_value", phaseErr, expErr.value);
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected < 7000", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic applyStimulus(input int c);
      waitCycle(c);
      ppsIn = 1'b1;
      @(negedge clk);
      ppsIn = 1'b0;
   endtask

   task automatic expectPps(input int c);
      ppsQ.push_back(c);
   endtask

   task automatic expectErr(input int c, input int v);
      errEvent_t ev;
      ev.cycle = c;
      ev.value = v;
      errQ.push_back(ev);
   endtask

   task automatic checkState(input int c, input int s, input int l);
      waitCycle(c);
      checkOutput("state", state, s);
      checkOutput("pps_locked", ppsLocked, l);
   endtask

   task automatic checkLeftover();
      checkOutput("pps_out_missing", ppsQ.size(), 0);
      checkOutput("phase_err_missing", errQ.size(), 0);
      ppsQ.delete();
      errQ.delete();
   endtask

   // Mid-cycle asynchronous reset; every output must clear without waiting for a clock.
   task automatic doReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_pps_out", ppsOut, 0);
      checkOutput("rst_state", state, 0);
      checkOutput("rst_pps_locked", ppsLocked, 0);
      checkOutput("rst_phase_err", phaseErr, 0);
      checkOutput("rst_phase_err_valid", phaseErrValid, 0);
      checkLeftover();
      enable       = 1'b1;
      forceFreerun = 1'b0;
      ppsIn        = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic lockSequence();
      expectPps(1); expectPps(501); expectPps(1501); expectPps(2501);
      expectErr(501, -500); expectErr(1501, 0); expectErr(2501, 0);
      applyStimulus(500);
      applyStimulus(1500);
      applyStimulus(2500);
   endtask

   initial begin
      // Free-run: pulses every F cycles from cycle 1, no phase strobes.
      doReset();
      expectPps(1); expectPps(1001); expectPps(2001);
      checkState(500, 0, 0);
      checkState(2100, 0, 0);

      // Acquisition, then phase steps while locked.
      doReset();
      expectPps(1); expectPps(501); expectPps(1501); expectPps(2501);
      expectPps(3501); expectPps(4501); expectPps(5451);
      expectErr(501, -500); expectErr(1501, 0); expectErr(2501, 0);
      expectErr(3506, 5); expectErr(4501, -5); expectErr(5451, -50);
      checkState(400, 0, 0);
      applyStimulus(500);
      checkState(501, 1, 0);
      applyStimulus(1500);
      checkState(2500, 1, 0);
      applyStimulus(2500);
      checkState(2501, 2, 1);
      applyStimulus(3505);
      checkState(3506, 2, 1);
      checkOutput("late_no_extra_pps", ppsOut, 0);
      applyStimulus(4500);
      checkState(4501, 2, 1);
      checkState(5450, 2, 1);
      applyStimulus(5450);
      checkState(5451, 1, 0);
      waitCycle(5600);

      // Holdover after loss of reference, then fallback to free-run.
      doReset();
      lockSequence();
      expectPps(3501); expectPps(4501); expectPps(5501); expectPps(6501);
      checkState(3511, 2, 1);
      checkState(3512, 3, 0);
      checkState(5501, 3, 0);
      checkState(5502, 0, 0);
      waitCycle(6600);

      // Recovery from holdover with a small late pulse.
      doReset();
      lockSequence();
      expectPps(3501); expectPps(4501); expectPps(5504);
      expectErr(4504, 3);
      checkState(3512, 3, 0);
      checkState(4503, 3, 0);
      applyStimulus(4503);
      checkState(4504, 2, 1);
      checkOutput("recover_no_dup_pps", ppsOut, 0);
      waitCycle(5600);

      // Overrides: force_freerun and enable=0 both ignore pps_in.
      doReset();
      lockSequence();
      expectPps(3501); expectPps(4201);
      expectErr(4201, -300);
      checkState(2501, 2, 1);
      waitCycle(3000);
      forceFreerun = 1'b1;
      checkState(3001, 0, 0);
      applyStimulus(3500);
      checkState(3501, 0, 0);
      waitCycle(3600);
      forceFreerun = 1'b0;
      enable       = 1'b0;
      applyStimulus(3800);
      checkState(3801, 0, 0);
      waitCycle(4000);
      enable = 1'b1;
      applyStimulus(4200);
      checkState(4201, 1, 0);
      waitCycle(4300);
      checkLeftover();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
